// File: rtl/core_icache.sv
// Direct-mapped instruction cache: combinational hit path from pc_idx, single-line
// refill over a valid/ready request channel and a beat-wise response channel.
module core_icache #(
    parameter int unsigned PC_W       = 64,
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned LINES      = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_idx,
    input  logic               fetch_en,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr_fetched,
    output logic               instr_valid,
    output logic               fetch_stall,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [PC_W-1:0]    mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data
);
    localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);
    localparam int unsigned IDX_BITS  = $clog2(LINES);
    localparam int unsigned OFF_BITS  = 2 + WORD_BITS;
    localparam int unsigned LINE_W    = PC_W - OFF_BITS;
    localparam int unsigned TAG_W     = LINE_W - IDX_BITS;
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REFILL} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [INSTR_W-1:0]   r_data [LINES][LINE_WORDS];
    logic [TAG_W-1:0]     r_tag  [LINES];
    logic [LINES-1:0]     r_valid;
    logic [LINE_W-1:0]    r_line;
    logic [WORD_BITS-1:0] r_cnt;
    logic                 r_flush_pending;

    logic [WORD_BITS-1:0] w_word;
    logic [IDX_BITS-1:0]  w_index;
    logic [TAG_W-1:0]     w_tag;
    logic [IDX_BITS-1:0]  w_fill_idx;
    logic [TAG_W-1:0]     w_fill_tag;
    logic                 w_hit;
    logic                 w_accept;
    logic                 w_beat;
    logic                 w_last_beat;
    logic                 w_unused_lsbs;

    assign w_word        = pc_idx[OFF_BITS-1:2];
    assign w_index       = pc_idx[OFF_BITS+IDX_BITS-1:OFF_BITS];
    assign w_tag         = pc_idx[PC_W-1:OFF_BITS+IDX_BITS];
    assign w_fill_idx    = r_line[IDX_BITS-1:0];
    assign w_fill_tag    = r_line[LINE_W-1:IDX_BITS];
    assign w_unused_lsbs = ^pc_idx[1:0];
    assign mem_req_addr  = {r_line, OFF_BITS'(0)};

    always_comb begin
        w_state_nxt   = r_state;
        w_hit         = fetch_en && (r_state == S_IDLE) && r_valid[w_index]
                        && (r_tag[w_index] == w_tag);
        instr_valid   = w_hit;
        instr_fetched = w_hit ? r_data[w_index][w_word] : NOP;
        fetch_stall   = fetch_en && !w_hit;
        mem_req_valid = (r_state == S_REQ);
        w_accept      = mem_req_valid && mem_req_ready;
        w_beat        = (r_state == S_REFILL) && mem_rsp_valid;
        w_last_beat   = w_beat && (r_cnt == WORD_BITS'(LINE_WORDS - 1));
        case (r_state)
            S_IDLE:   if (fetch_en && !w_hit) w_state_nxt = S_REQ;
            S_REQ:    if (w_accept)           w_state_nxt = S_REFILL;
            S_REFILL: if (w_last_beat)        w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The refilling line loses its valid bit at acceptance, so partial data never hits;
    // a flush arriving on the final beat still leaves that line invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid         <= '0;
            r_cnt           <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && fetch_en && !w_hit)
                r_line <= pc_idx[PC_W-1:OFF_BITS];
            if (flush) begin
                r_valid <= '0;
                if (r_state != S_IDLE) r_flush_pending <= 1'b1;
            end
            if (w_accept) begin
                r_valid[w_fill_idx] <= 1'b0;
                r_cnt               <= '0;
            end
            if (w_beat) r_cnt <= r_cnt + 1'b1;
            if (w_last_beat) begin
                r_valid[w_fill_idx] <= !(r_flush_pending || flush);
                r_flush_pending     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_beat)      r_data[w_fill_idx][r_cnt] <= mem_rsp_data;
        if (!rst && w_last_beat) r_tag[w_fill_idx]         <= w_fill_tag;
    end
endmodule
